// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline and branch_predictor.
//   master : pipeline side; drives fetch lookup and resolve info, reads predictions.
//   slave  : predictor side.
// Fetch : lookup_en, lookup_pc, stall -> pred_hit, pred_taken, pred_target, pred_ghr
// Resolve: upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
//          upd_pred_target, upd_ghr -> mispredict, redirect_pc
// Stats  : br_cnt, mp_cnt
interface branch_predictor_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned STAT_W = 16
) ();
  logic              lookup_en;
  logic [ADDR_W-1:0] lookup_pc;
  logic              stall;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [IDX_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic [IDX_W-1:0]  upd_ghr;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] mp_cnt;

  modport master (
    output lookup_en, lookup_pc, stall,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target, upd_ghr,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
    input  mispredict, redirect_pc, br_cnt, mp_cnt
  );

  modport slave (
    input  lookup_en, lookup_pc, stall,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target, upd_ghr,
    output pred_hit, pred_taken, pred_target, pred_ghr,
    output mispredict, redirect_pc, br_cnt, mp_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB, saturating direction
// counters (bimodal or gshare indexing) and a speculative global history.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bp       : branch_predictor_if slave (lookup, resolve/update, statistics)
// Predictions and mispredict/redirect are combinational; all table, history
// and statistics state updates on the rising clock edge.
module branch_predictor #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned MODE    = 0,
  parameter int unsigned STAT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((2 ** (CTR_W - 1)) - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];
  logic [IDX_W-1:0]   ghr_q, ghr_d;
  logic [STAT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0]  mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0] l_idx, l_cidx, u_idx, u_cidx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             hit_c, taken_c, mispredict_c;

  // Table indices for the fetch lookup and the resolving branch.
  always_comb begin
    l_idx  = bp.lookup_pc[IDX_W-1:0];
    l_tag  = bp.lookup_pc[ADDR_W-1:IDX_W];
    l_cidx = (MODE == 1) ? (l_idx ^ ghr_q) : l_idx;
    u_idx  = bp.upd_pc[IDX_W-1:0];
    u_tag  = bp.upd_pc[ADDR_W-1:IDX_W];
    u_cidx = (MODE == 1) ? (u_idx ^ bp.upd_ghr) : u_idx;
  end

  // Lookup reads pre-update contents; there is no same-cycle bypass.
  assign hit_c   = bp.lookup_en & valid_q[l_idx] & (tag_q[l_idx] == l_tag);
  assign taken_c = hit_c & ctr_q[l_cidx][CTR_W-1];

  assign mispredict_c = bp.upd_valid &
                        ((bp.upd_taken != bp.upd_pred_taken) |
                         (bp.upd_taken & (bp.upd_target != bp.upd_pred_target)));

  assign bp.pred_hit    = hit_c;
  assign bp.pred_taken  = taken_c;
  assign bp.pred_target = taken_c ? target_q[l_idx] : bp.lookup_pc + ADDR_W'(1);
  assign bp.pred_ghr    = ghr_q;
  assign bp.mispredict  = mispredict_c;
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + ADDR_W'(1);
  assign bp.br_cnt      = br_cnt_q;
  assign bp.mp_cnt      = mp_cnt_q;

  // Next-state: table training, history shift/recovery, statistics.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    ghr_d    = ghr_q;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;

    if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        if (ctr_q[u_cidx] != '1) ctr_d[u_cidx] = ctr_q[u_cidx] + CTR_W'(1);
        // Taken branches allocate, replacing any alias at this index.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bp.upd_target;
      end else if (ctr_q[u_cidx] != '0) begin
        ctr_d[u_cidx] = ctr_q[u_cidx] - CTR_W'(1);
      end
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + STAT_W'(1);
    end

    if (mispredict_c && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + STAT_W'(1);

    // Recovery from the resolving branch wins over the speculative shift.
    if (mispredict_c) begin
      ghr_d = IDX_W'({bp.upd_ghr, bp.upd_taken});
    end else if (bp.lookup_en && !bp.stall && hit_c) begin
      ghr_d = IDX_W'({ghr_q, taken_c});
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      ghr_q    <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      ghr_q    <= ghr_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// dut0: bimodal, 2-bit counters; dut1: gshare, 2-bit counters;
// dut2: gshare, 3-bit counters, 4-bit statistics (exercises saturation).
// Directed table and sequences use constant expectations; the random phase
// compares all three against a reference model kept as plain integer arrays.
module tb_branch_predictor;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en, stall, upd_valid, upd_taken, upd_pred_taken;
  logic [15:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
  logic [3:0]  upd_ghr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(16), .IDX_W(4), .STAT_W(16)) if0 ();
  branch_predictor_if #(.ADDR_W(16), .IDX_W(4), .STAT_W(16)) if1 ();
  branch_predictor_if #(.ADDR_W(16), .IDX_W(4), .STAT_W(4))  if2 ();

  assign if0.lookup_en = lookup_en, if0.lookup_pc = lookup_pc, if0.stall = stall,
         if0.upd_valid = upd_valid, if0.upd_pc = upd_pc, if0.upd_taken = upd_taken,
         if0.upd_target = upd_target, if0.upd_pred_taken = upd_pred_taken,
         if0.upd_pred_target = upd_pred_target, if0.upd_ghr = upd_ghr;
  assign if1.lookup_en = lookup_en, if1.lookup_pc = lookup_pc, if1.stall = stall,
         if1.upd_valid = upd_valid, if1.upd_pc = upd_pc, if1.upd_taken = upd_taken,
         if1.upd_target = upd_target, if1.upd_pred_taken = upd_pred_taken,
         if1.upd_pred_target = upd_pred_target, if1.upd_ghr = upd_ghr;
  assign if2.lookup_en = lookup_en, if2.lookup_pc = lookup_pc, if2.stall = stall,
         if2.upd_valid = upd_valid, if2.upd_pc = upd_pc, if2.upd_taken = upd_taken,
         if2.upd_target = upd_target, if2.upd_pred_taken = upd_pred_taken,
         if2.upd_pred_target = upd_pred_target, if2.upd_ghr = upd_ghr;

  branch_predictor #(.ADDR_W(16), .ENTRIES(16), .CTR_W(2), .MODE(0), .STAT_W(16))
    dut0 (.clk(clk), .rst(rst), .bp(if0));
  branch_predictor #(.ADDR_W(16), .ENTRIES(16), .CTR_W(2), .MODE(1), .STAT_W(16))
    dut1 (.clk(clk), .rst(rst), .bp(if1));
  branch_predictor #(.ADDR_W(16), .ENTRIES(16), .CTR_W(3), .MODE(1), .STAT_W(4))
    dut2 (.clk(clk), .rst(rst), .bp(if2));

  // ---------------- reference model ----------------
  int m_mode [NDUT];
  int m_ctrw [NDUT];
  int m_statw[NDUT];
  int mv  [NDUT][16];
  int mtag[NDUT][16];
  int mtgt[NDUT][16];
  int mctr[NDUT][16];
  int mghr[NDUT];
  int mbr [NDUT];
  int mmp [NDUT];
  int e_hit[NDUT], e_taken[NDUT], e_target[NDUT], e_ghr[NDUT];
  int e_mp, e_redir;

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 16; i++) begin
        mv[d][i]   = 0;
        mtag[d][i] = 0;
        mtgt[d][i] = 0;
        mctr[d][i] = (1 << (m_ctrw[d] - 1)) - 1;
      end
      mghr[d] = 0;
      mbr[d]  = 0;
      mmp[d]  = 0;
    end
  endtask

  // Combinational view of the current inputs against the model state.
  task automatic model_eval();
    int pc, idx, cidx;
    pc  = int'(lookup_pc);
    idx = pc % 16;
    for (int d = 0; d < NDUT; d++) begin
      e_hit[d]    = (lookup_en && mv[d][idx] != 0 && mtag[d][idx] == pc / 16) ? 1 : 0;
      cidx        = (m_mode[d] == 1) ? (idx ^ mghr[d]) : idx;
      e_taken[d]  = (e_hit[d] != 0 && mctr[d][cidx] >= (1 << (m_ctrw[d] - 1))) ? 1 : 0;
      e_target[d] = (e_taken[d] != 0) ? mtgt[d][idx] : (pc + 1) % 65536;
      e_ghr[d]    = mghr[d];
    end
    e_mp = (upd_valid && ((upd_taken != upd_pred_taken) ||
                          (upd_taken && upd_target != upd_pred_target))) ? 1 : 0;
    e_redir = upd_taken ? int'(upd_target) : (int'(upd_pc) + 1) % 65536;
  endtask

  // Clock-edge effect of the same inputs (uses values from model_eval).
  task automatic model_commit();
    int uidx, ucidx, cmax, smax;
    uidx = int'(upd_pc) % 16;
    for (int d = 0; d < NDUT; d++) begin
      cmax  = (1 << m_ctrw[d]) - 1;
      smax  = (1 << m_statw[d]) - 1;
      ucidx = (m_mode[d] == 1) ? (uidx ^ int'(upd_ghr)) : uidx;
      if (upd_valid) begin
        if (upd_taken) begin
          if (mctr[d][ucidx] < cmax) mctr[d][ucidx]++;
          mv[d][uidx]   = 1;
          mtag[d][uidx] = int'(upd_pc) / 16;
          mtgt[d][uidx] = int'(upd_target);
        end else if (mctr[d][ucidx] > 0) begin
          mctr[d][ucidx]--;
        end
        if (mbr[d] < smax) mbr[d]++;
      end
      if (e_mp != 0) begin
        if (mmp[d] < smax) mmp[d]++;
        mghr[d] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 16;
      end else if (lookup_en && !stall && e_hit[d] != 0) begin
        mghr[d] = (mghr[d] * 2 + e_taken[d]) % 16;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [31:0] hit, input logic [31:0] tk,
                         input logic [31:0] tgt, input logic [31:0] ghr,
                         input logic [31:0] mp, input logic [31:0] redir,
                         input logic [31:0] br, input logic [31:0] mpc);
    chk($sformatf("rand d%0d pred_hit", d),    hit,   32'(e_hit[d]));
    chk($sformatf("rand d%0d pred_taken", d),  tk,    32'(e_taken[d]));
    chk($sformatf("rand d%0d pred_target", d), tgt,   32'(e_target[d]));
    chk($sformatf("rand d%0d pred_ghr", d),    ghr,   32'(e_ghr[d]));
    chk($sformatf("rand d%0d mispredict", d),  mp,    32'(e_mp));
    chk($sformatf("rand d%0d redirect_pc", d), redir, 32'(e_redir));
    chk($sformatf("rand d%0d br_cnt", d),      br,    32'(mbr[d]));
    chk($sformatf("rand d%0d mp_cnt", d),      mpc,   32'(mmp[d]));
  endtask

  task automatic idle();
    lookup_en = 1'b0; lookup_pc = '0; stall = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; upd_ghr = '0;
  endtask

  task automatic lookup(input logic [15:0] pc, input logic stl);
    lookup_en = 1'b1; lookup_pc = pc; stall = stl;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                     input logic ptk, input logic [15:0] ptgt, input logic [3:0] ghr);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt; upd_ghr = ghr;
  endtask

  // Sample point: falling edge, model evaluated for the same inputs.
  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    if (!rst) model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 16'hFFFF;
    return 16'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
  endfunction

  // ---------------- directed vectors (dut0, bimodal) ----------------
  typedef struct {
    logic        le;
    logic [15:0] lpc;
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic        upt;
    logic [15:0] uptgt;
    logic        hit;
    logic        tk;
    logic [15:0] tgt;
    logic        mp;
    logic [15:0] redir;
    logic [15:0] br;
    logic [15:0] mpc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(int le, int lpc, int uv, int upc, int ut, int utgt,
                              int upt, int uptgt, int hit, int tk, int tgt,
                              int mp, int redir, int br, int mpc);
    vec_t v;
    v.le = 1'(le);   v.lpc = 16'(lpc); v.uv = 1'(uv);   v.upc = 16'(upc);
    v.ut = 1'(ut);   v.utgt = 16'(utgt); v.upt = 1'(upt); v.uptgt = 16'(uptgt);
    v.hit = 1'(hit); v.tk = 1'(tk);    v.tgt = 16'(tgt); v.mp = 1'(mp);
    v.redir = 16'(redir); v.br = 16'(br); v.mpc = 16'(mpc);
    return v;
  endfunction

  initial begin
    m_mode  = '{0, 1, 1};
    m_ctrw  = '{2, 2, 3};
    m_statw = '{16, 16, 4};

    //              le lpc     uv upc     ut utgt    upt uptgt   hit tk tgt     mp redir   br  mpc
    tbl[0]  = mk(1, 'h0010, 0, 'h0000, 0, 'h0000, 0, 'h0000, 0, 0, 'h0011, 0, 'h0001, 0,  0);
    tbl[1]  = mk(0, 'h0000, 1, 'h0012, 1, 'h0040, 0, 'h0013, 0, 0, 'h0001, 1, 'h0040, 0,  0);
    tbl[2]  = mk(1, 'h0012, 0, 'h0000, 0, 'h0000, 0, 'h0000, 1, 1, 'h0040, 0, 'h0001, 1,  1);
    tbl[3]  = mk(1, 'h0022, 0, 'h0000, 0, 'h0000, 0, 'h0000, 0, 0, 'h0023, 0, 'h0001, 1,  1);
    tbl[4]  = mk(0, 'h0000, 1, 'hFFFF, 0, 'h0000, 0, 'h0000, 0, 0, 'h0001, 0, 'h0000, 1,  1);
    tbl[5]  = mk(0, 'h0000, 1, 'h0012, 1, 'h0040, 1, 'h0040, 0, 0, 'h0001, 0, 'h0040, 2,  1);
    tbl[6]  = mk(0, 'h0000, 1, 'h0012, 1, 'h0040, 1, 'h0040, 0, 0, 'h0001, 0, 'h0040, 3,  1);
    tbl[7]  = mk(0, 'h0000, 1, 'h0012, 1, 'h0040, 1, 'h0040, 0, 0, 'h0001, 0, 'h0040, 4,  1);
    tbl[8]  = mk(0, 'h0000, 1, 'h0012, 1, 'h0040, 1, 'h0040, 0, 0, 'h0001, 0, 'h0040, 5,  1);
    tbl[9]  = mk(1, 'h0012, 1, 'h0012, 0, 'h0000, 1, 'h0040, 1, 1, 'h0040, 1, 'h0013, 6,  1);
    tbl[10] = mk(1, 'h0012, 1, 'h0012, 0, 'h0000, 1, 'h0040, 1, 1, 'h0040, 1, 'h0013, 7,  2);
    tbl[11] = mk(1, 'h0012, 1, 'h0012, 0, 'h0000, 0, 'h0013, 1, 0, 'h0013, 0, 'h0013, 8,  3);
    tbl[12] = mk(1, 'h0012, 1, 'h0012, 0, 'h0000, 0, 'h0013, 1, 0, 'h0013, 0, 'h0013, 9,  3);
    tbl[13] = mk(1, 'h0012, 0, 'h0000, 0, 'h0000, 0, 'h0000, 1, 0, 'h0013, 0, 'h0001, 10, 3);
    tbl[14] = mk(1, 'h0005, 1, 'h0005, 1, 'h0080, 0, 'h0006, 0, 0, 'h0006, 1, 'h0080, 10, 3);
    tbl[15] = mk(1, 'h0005, 0, 'h0000, 0, 'h0000, 0, 'h0000, 1, 1, 'h0080, 0, 'h0001, 11, 4);

    // ---- reset state ----
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst d0 pred_hit",   32'(if0.pred_hit),   32'd0);
    chk("rst d0 pred_taken", 32'(if0.pred_taken), 32'd0);
    chk("rst d0 pred_ghr",   32'(if0.pred_ghr),   32'd0);
    chk("rst d0 br_cnt",     32'(if0.br_cnt),     32'd0);
    chk("rst d0 mp_cnt",     32'(if0.mp_cnt),     32'd0);
    chk("rst d1 pred_ghr",   32'(if1.pred_ghr),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- table: bimodal basics, aliasing, wrap, saturation, no bypass ----
    for (int i = 0; i < 16; i++) begin
      idle();
      lookup_en = tbl[i].le; lookup_pc = tbl[i].lpc;
      upd_valid = tbl[i].uv; upd_pc = tbl[i].upc; upd_taken = tbl[i].ut;
      upd_target = tbl[i].utgt; upd_pred_taken = tbl[i].upt;
      upd_pred_target = tbl[i].uptgt;
      sample();
      chk($sformatf("vec%0d pred_hit", i),    32'(if0.pred_hit),    32'(tbl[i].hit));
      chk($sformatf("vec%0d pred_taken", i),  32'(if0.pred_taken),  32'(tbl[i].tk));
      chk($sformatf("vec%0d pred_target", i), 32'(if0.pred_target), 32'(tbl[i].tgt));
      chk($sformatf("vec%0d mispredict", i),  32'(if0.mispredict),  32'(tbl[i].mp));
      chk($sformatf("vec%0d redirect_pc", i), 32'(if0.redirect_pc), 32'(tbl[i].redir));
      chk($sformatf("vec%0d br_cnt", i),      32'(if0.br_cnt),      32'(tbl[i].br));
      chk($sformatf("vec%0d mp_cnt", i),      32'(if0.mp_cnt),      32'(tbl[i].mpc));
      advance();
    end

    // ---- gshare history: shift, stall hold, recovery override (dut1) ----
    do_reset();
    upd(16'h0012, 1'b1, 16'h0040, 1'b1, 16'h0040, 4'h0);
    sample();
    chk("ghr train mispredict", 32'(if1.mispredict), 32'd0);
    advance();
    idle(); lookup(16'h0012, 1'b0);
    sample();
    chk("ghr hit pred_hit",   32'(if1.pred_hit),   32'd1);
    chk("ghr hit pred_taken", 32'(if1.pred_taken), 32'd1);
    chk("ghr hit pred_ghr",   32'(if1.pred_ghr),   32'd0);
    advance();
    idle(); lookup(16'h0012, 1'b1);
    sample();
    chk("ghr shifted",        32'(if1.pred_ghr),   32'd1);
    chk("ghr stall taken",    32'(if1.pred_taken), 32'd0);
    advance();
    idle(); lookup(16'h0012, 1'b0);
    upd(16'h0030, 1'b0, 16'h0000, 1'b1, 16'h0040, 4'h0);
    sample();
    chk("ghr held by stall",    32'(if1.pred_ghr),    32'd1);
    chk("ghr recov mispredict", 32'(if1.mispredict),  32'd1);
    chk("ghr recov redirect",   32'(if1.redirect_pc), 32'h0031);
    advance();
    idle();
    sample();
    chk("ghr recovered", 32'(if1.pred_ghr), 32'd0);
    advance();

    // ---- mid-stream reset discards learned state (dut0) ----
    do_reset();
    upd(16'h0101, 1'b1, 16'h0500, 1'b0, 16'h0102, 4'h0); sample(); advance();
    upd(16'h0203, 1'b1, 16'h0600, 1'b0, 16'h0204, 4'h0); sample(); advance();
    upd(16'h0307, 1'b1, 16'h0700, 1'b0, 16'h0308, 4'h0); sample(); advance();
    idle(); lookup(16'h0203, 1'b0);
    sample();
    chk("pre-rst pred_hit", 32'(if0.pred_hit), 32'd1);
    chk("pre-rst mp_cnt",   32'(if0.mp_cnt),   32'd3);
    advance();
    idle(); lookup(16'h0101, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("in-rst pred_hit", 32'(if0.pred_hit), 32'd0);
    chk("in-rst br_cnt",   32'(if0.br_cnt),   32'd0);
    chk("in-rst mp_cnt",   32'(if0.mp_cnt),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      lookup(16'(16'h0101 + i * 16'h0102 + ((i == 2) ? 16'h0002 : 16'h0000)), 1'b0);
      sample();
      chk($sformatf("post-rst pc%0h pred_hit", lookup_pc), 32'(if0.pred_hit), 32'd0);
      advance();
    end
    idle(); upd(16'h0101, 1'b1, 16'h0500, 1'b1, 16'h0500, 4'h0); sample(); advance();
    idle(); upd(16'h0101, 1'b0, 16'h0000, 1'b0, 16'h0102, 4'h0); sample(); advance();
    idle(); lookup(16'h0101, 1'b0);
    sample();
    chk("post-rst ctr pred_hit",   32'(if0.pred_hit),    32'd1);
    chk("post-rst ctr pred_taken", 32'(if0.pred_taken),  32'd0);
    chk("post-rst ctr target",     32'(if0.pred_target), 32'h0102);
    chk("post-rst br_cnt",         32'(if0.br_cnt),      32'd2);
    chk("post-rst mp_cnt",         32'(if0.mp_cnt),      32'd0);
    advance();

    // ---- randomized traffic against the model (all DUTs) ----
    for (int n = 0; n < 1500; n++) begin
      lookup_en       = ($urandom_range(0, 3) != 0);
      lookup_pc       = rand_pc();
      stall           = ($urandom_range(0, 4) == 0);
      upd_valid       = ($urandom_range(0, 1) != 0);
      upd_pc          = rand_pc();
      upd_taken       = 1'($urandom);
      upd_target      = rand_pc();
      upd_pred_taken  = 1'($urandom);
      upd_pred_target = ($urandom_range(0, 2) == 0) ? rand_pc() :
                        (upd_taken ? upd_target : 16'(upd_pc + 16'd1));
      upd_ghr         = 4'($urandom_range(0, 15));
      sample();
      cmp_dut(0, 32'(if0.pred_hit), 32'(if0.pred_taken), 32'(if0.pred_target),
              32'(if0.pred_ghr), 32'(if0.mispredict), 32'(if0.redirect_pc),
              32'(if0.br_cnt), 32'(if0.mp_cnt));
      cmp_dut(1, 32'(if1.pred_hit), 32'(if1.pred_taken), 32'(if1.pred_target),
              32'(if1.pred_ghr), 32'(if1.mispredict), 32'(if1.redirect_pc),
              32'(if1.br_cnt), 32'(if1.mp_cnt));
      cmp_dut(2, 32'(if2.pred_hit), 32'(if2.pred_taken), 32'(if2.pred_target),
              32'(if2.pred_ghr), 32'(if2.mispredict), 32'(if2.redirect_pc),
              32'(if2.br_cnt), 32'(if2.mp_cnt));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction unit for the pipelined 16-bit core. It replaces late flag-based branch resolution with fetch-stage prediction plus execute-stage verification.
- Contents: a direct-mapped branch target buffer (BTB), a table of saturating direction counters, and a speculative global history register (GHR). Index mode is bimodal or gshare.
- Fetch queries it every cycle. The resolve stage updates it and receives the mispredict/redirect signal.

Parameters:
- ADDR_W, 16, PC width; PC is word-addressed, next sequential PC = pc+1.
- ENTRIES, 16, BTB and counter-table depth; power of 2. IDX_W = log2(ENTRIES), TAG_W = ADDR_W-IDX_W.
- CTR_W, 2, direction counter width, CTR_W >= 1.
- MODE, 0, counter index select: 0 = bimodal (pc index), 1 = gshare (pc index XOR GHR). GHR is IDX_W bits.
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- lookup_en  in  1  fetch is requesting a prediction.
- lookup_pc  in  ADDR_W  fetch PC.
- stall  in  1  fetch stalled; lookup repeats next cycle.
- pred_hit  out  1  BTB tag match for lookup_pc.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted next PC.
- pred_ghr  out  IDX_W  GHR value used for this lookup; pipeline carries it to resolve.
- upd_valid  in  1  a branch resolved this cycle.
- upd_pc  in  ADDR_W  resolved branch PC.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction carried with the branch.
- upd_pred_target  in  ADDR_W  predicted next PC carried with the branch.
- upd_ghr  in  IDX_W  pred_ghr carried with the branch.
- mispredict  out  1  resolve disagrees with prediction.
- redirect_pc  out  ADDR_W  correct next PC on mispredict.
- br_cnt  out  STAT_W  resolved-branch count.
- mp_cnt  out  STAT_W  mispredict count.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset clears:
  - all BTB valid bits;
  - all counters to weakly-not-taken, 2^(CTR_W-1)-1;
  - GHR, br_cnt and mp_cnt to 0.
  All outputs derived from this state (pred_* with lookup_en=0, counts) read 0 while rst is high.
- Lookup, combinational, same cycle:
  - idx = lookup_pc[IDX_W-1:0].
  - pred_hit = lookup_en & valid[idx] & (tag[idx] == lookup_pc[ADDR_W-1:IDX_W]).
  - cidx = idx (MODE 0) or idx ^ GHR (MODE 1).
  - pred_taken = pred_hit & ctr[cidx] MSB.
  - pred_target = pred_taken ? target[idx] : lookup_pc+1, mod 2^ADDR_W (0xFFFF wraps to 0x0000).
  - pred_ghr = GHR.
- Speculative history: when lookup_en & ~stall & pred_hit, GHR <= {GHR[IDX_W-2:0], pred_taken} at the clock edge. stall=1 freezes GHR.
- Verify, combinational:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+1 (wraps).
- Update at the clock edge when upd_valid:
  - ucidx = upd_pc idx (MODE 0) or upd_pc idx ^ upd_ghr (MODE 1).
  - Counter: increment saturating at all-ones if upd_taken, else decrement saturating at 0.
  - If upd_taken: BTB[idx] <= valid=1, tag, upd_target; this overwrites any alias.
  - Not-taken never allocates or invalidates a BTB entry.
- Recovery: on mispredict, GHR <= {upd_ghr[IDX_W-2:0], upd_taken}. This overrides any same-cycle speculative shift.
- Same-cycle lookup and update to the same entry: lookup sees pre-update contents; no bypass.
- Statistics: br_cnt increments on upd_valid; mp_cnt increments on mispredict. Both saturate at all-ones.
- Reset asserted mid-operation discards all learned state immediately. The first cycle after deassert behaves as post-reset.

Test Plan:
- Reset, then lookup_en=1, lookup_pc=0x0010 -> pred_hit=0, pred_taken=0, pred_target=0x0011, br_cnt=mp_cnt=0.
- upd_valid, upd_pc=0x0012, upd_taken=1, upd_target=0x0040, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x0040. Next cycle: mp_cnt=1, br_cnt=1; lookup 0x0012 -> pred_hit=1, counter 2, pred_taken=1, pred_target=0x0040.
- After the previous scenario, lookup 0x0022 (same index 2, different tag) -> pred_hit=0, pred_target=0x0023. Then a correctly predicted not-taken update at pc=0xFFFF -> mispredict=0, redirect_pc=0x0000.
- Saturation: 4 taken updates to 0x0012 -> counter 3; 1 not-taken -> counter 2, still predicts taken; 2 more not-taken -> counter 0; a 3rd not-taken -> stays 0, pred_taken=0.
- MODE=1: hit with taken prediction moves GHR 0000 -> 0001. stall=1 with a repeated hit -> GHR holds 0001. Mispredict with upd_ghr=0000, upd_taken=0 in the same cycle as another hit -> GHR=0000 next cycle.
- Populate 3 entries, then pulse rst mid-stream -> pred_hit=0 for all three PCs, counters at 1, counts 0.
